fidus_clock_monitor: RTL
========================

FIDUS_CLOCK_MONITOR -- requirements
Module: fidus_clock_monitor

Interface
REQ-001 Parameter CNT_W, default 16, width of all period/high-time counters and limits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on the monitored clock (legal 2..4).
REQ-003 i_clock  input  1  sampling clock; all logic on its rising edge; SHALL be at least 4x the monitored clock frequency.
REQ-004 i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_mon_clock  input  1  clock under test (output of the clock generator stage), treated as asynchronous data.
REQ-006 i_enable  input  1  1 = monitor runs; 0 = return to IDLE.
REQ-007 i_clear  input  1  one-cycle pulse; clears sticky error flags.
REQ-008 i_period_min / i_period_max  input  CNT_W  allowed period, in i_clock cycles, inclusive.
REQ-009 i_high_min / i_high_max  input  CNT_W  allowed high time, in i_clock cycles, inclusive.
REQ-010 i_timeout  input  CNT_W  cycles without a rising edge before the clock is declared stopped; 0 disables the check.
REQ-011 o_meas_valid  output  1  one-cycle pulse; new measurement available.
REQ-012 o_period / o_high_time  output  CNT_W  last completed measurements.
REQ-013 o_period_err / o_high_err / o_stopped  output  1  sticky error flags.

Function
REQ-014 SHALL pass i_mon_clock through SYNC_STAGES flops, then one delay flop; rising edge = sync & ~delay, falling edge = ~sync & delay.
REQ-015 States: IDLE, ARM, MEASURE.
REQ-016 IDLE -> ARM when i_enable=1; any state -> IDLE within one cycle when i_enable=0.
REQ-017 ARM: counters are held at 0; the first rising edge starts counting and moves to MEASURE; no o_meas_valid is produced.
REQ-018 MEASURE: the period counter increments every cycle; the high counter increments while synchronized level=1 and freezes after the falling edge.
REQ-019 On each rising edge in MEASURE: o_period <= period count + 1, o_high_time <= high count; o_meas_valid=1 in the following cycle; both counters restart (period=0, high=0).
REQ-020 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 A measurement with o_period outside [i_period_min, i_period_max] SHALL set o_period_err in the same cycle as o_meas_valid.
REQ-022 A measurement with o_high_time outside [i_high_min, i_high_max] SHALL set o_high_err in the same cycle as o_meas_valid.
REQ-023 In ARM or MEASURE, with i_timeout != 0: when the cycles since the last rising edge (or since entering ARM) reach i_timeout, o_stopped SHALL be set and the state SHALL go to ARM.
REQ-024 i_clear SHALL clear all three flags; if an error event occurs in the same cycle, the set SHALL win.
REQ-025 Limit inputs are sampled at each comparison; changing them mid-period affects only later comparisons.
REQ-026 A falling edge seen in ARM is ignored.

Reset
REQ-027 While i_reset_n=0: state=IDLE, synchronizer and delay flops=0, counters=0, all outputs=0.
REQ-028 Reset deassertion mid-period SHALL restart from ARM (if i_enable=1) with no stale measurement emitted.

Structure
REQ-029 A shared package fidus_clock_monitor_pkg SHALL hold the state encoding (IDLE=0, ARM=1, MEASURE=2) and the default CNT_W.
REQ-030 One sub-module, fidus_sync_edge_det (synchronizer, delay flop, rise/fall pulses), SHALL be instantiated; everything else stays flat.

Verification
REQ-031 i_clock 10 ns, monitored clock 100 ns at 50% duty, limits period 9..11, high 4..6 -> o_period=10, o_high_time=5 on every valid pulse; no error flags.
REQ-032 Same monitored clock with period limits 12..14 -> o_period_err set on the first valid pulse and held; i_clear pulse with the clock unchanged -> flag clears, then sets again on the next measurement.
REQ-033 Monitored clock at 30% duty -> o_high_time=3, o_high_err=1, o_period_err=0.
REQ-034 i_timeout=25, monitored clock held low after 3 periods -> o_stopped=1 25 cycles after the last rising edge, state=ARM; restarting the clock produces the first o_meas_valid only after two rising edges.
REQ-035 i_timeout=0 and a monitored clock with a 70000-cycle period (CNT_W=16) -> o_period=65535 (saturated), o_period_err=1, o_stopped stays 0.
REQ-036 Assert i_reset_n=0 mid-period, then release it -> all outputs are 0 during reset and no o_meas_valid occurs until two new rising edges.

Source files
------------

// File: rtl/fidus_clock_monitor_pkg.sv
`default_nettype none
// ============================================================================
// fidus_clock_monitor_pkg : state encoding and defaults for the clock monitor
// Revision: 1.0
// ============================================================================
package fidus_clock_monitor_pkg;

  localparam int CNT_W_DEFAULT = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fidus_clock_monitor_sync_edge_det.sv
`default_nettype none
// ============================================================================
// fidus_sync_edge_det : multi-flop synchronizer plus delay flop, edge pulses
// Revision: 1.0
// ============================================================================
module fidus_sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delay_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
      delay_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~delay_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & delay_q;

endmodule
`default_nettype wire

// File: rtl/fidus_clock_monitor.sv
`default_nettype none
// ============================================================================
// fidus_clock_monitor : measures period/high time of a clock, flags violations
// Revision: 1.0
// ============================================================================
module fidus_clock_monitor
  import fidus_clock_monitor_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_mon_clock,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_period_min,
  input  logic [CNT_W-1:0] i_period_max,
  input  logic [CNT_W-1:0] i_high_min,
  input  logic [CNT_W-1:0] i_high_max,
  input  logic [CNT_W-1:0] i_timeout,
  output logic             o_meas_valid,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high_time,
  output logic             o_period_err,
  output logic             o_high_err,
  output logic             o_stopped
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic mon_level, mon_rise, mon_fall;

  fidus_sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk_i   (i_clock),
    .rst_ni  (i_reset_n),
    .async_i (i_mon_clock),
    .level_o (mon_level),
    .rise_o  (mon_rise),
    .fall_o  (mon_fall)
  );

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] since_rise_q, since_rise_d;
  logic             meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             period_err_q, period_err_d;
  logic             high_err_q, high_err_d;
  logic             stopped_q, stopped_d;

  logic [CNT_W:0]   since_rise_next;
  logic             timeout_hit;
  logic [CNT_W-1:0] period_new;

  // Timeout fires on the cycle that would make the count reach i_timeout.
  assign since_rise_next = {1'b0, since_rise_q} + {1'b0, CNT_ONE};
  assign timeout_hit     = (i_timeout != '0) && (since_rise_next >= {1'b0, i_timeout});
  assign period_new      = sat_inc(period_cnt_q);

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    since_rise_d = since_rise_q;
    meas_valid_d = 1'b0;
    period_d     = period_q;
    high_time_d  = high_time_q;
    period_err_d = period_err_q & ~i_clear;
    high_err_d   = high_err_q & ~i_clear;
    stopped_d    = stopped_q & ~i_clear;

    case (state_q)
      ST_IDLE: begin
        period_cnt_d = '0;
        high_cnt_d   = '0;
        since_rise_d = '0;
        if (i_enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        period_cnt_d = '0;
        high_cnt_d   = '0;
        if (mon_rise) begin
          state_d      = ST_MEASURE;
          since_rise_d = '0;
        end else if (timeout_hit) begin
          stopped_d    = 1'b1;
          since_rise_d = '0;
        end else begin
          since_rise_d = sat_inc(since_rise_q);
        end
      end
      ST_MEASURE: begin
        if (mon_rise) begin
          meas_valid_d = 1'b1;
          period_d     = period_new;
          high_time_d  = high_cnt_q;
          if ((period_new < i_period_min) || (period_new > i_period_max)) period_err_d = 1'b1;
          if ((high_cnt_q < i_high_min) || (high_cnt_q > i_high_max)) high_err_d = 1'b1;
          period_cnt_d = '0;
          high_cnt_d   = '0;
          since_rise_d = '0;
        end else if (timeout_hit) begin
          stopped_d    = 1'b1;
          state_d      = ST_ARM;
          period_cnt_d = '0;
          high_cnt_d   = '0;
          since_rise_d = '0;
        end else begin
          period_cnt_d = sat_inc(period_cnt_q);
          since_rise_d = sat_inc(since_rise_q);
          // High time includes the cycle on which the fall is seen.
          if (mon_level || mon_fall) high_cnt_d = sat_inc(high_cnt_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!i_enable) state_d = ST_IDLE;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      since_rise_q <= '0;
      meas_valid_q <= 1'b0;
      period_q     <= '0;
      high_time_q  <= '0;
      period_err_q <= 1'b0;
      high_err_q   <= 1'b0;
      stopped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      since_rise_q <= since_rise_d;
      meas_valid_q <= meas_valid_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      period_err_q <= period_err_d;
      high_err_q   <= high_err_d;
      stopped_q    <= stopped_d;
    end
  end

  assign o_meas_valid = meas_valid_q;
  assign o_period     = period_q;
  assign o_high_time  = high_time_q;
  assign o_period_err = period_err_q;
  assign o_high_err   = high_err_q;
  assign o_stopped    = stopped_q;

endmodule
`default_nettype wire
